// File: rtl/cpu_ctrl_seq.sv
// Microcode sequencer for the 8-bit CPU: Moore FSM stepping fetch/decode/execute micro-steps.
// Optional feature macro: CTRL_COND_JMP_EN enables the JC/JZ conditional jumps.
module cpu_ctrl_seq (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [3:0] ir_opcode,
  input  logic       carry_f,
  input  logic       zero_f,
  output logic       pc_out,
  output logic       pc_inc,
  output logic       pc_load,
  output logic       mar_wen,
  output logic       ram_oen,
  output logic       ram_wen,
  output logic       ir_wen,
  output logic       ir_oen,
  output logic       a_wen,
  output logic       a_oen,
  output logic       b_wen,
  output logic       alu_oen,
  output logic       alu_sub,
  output logic       flags_wen,
  output logic       out_wen,
  output logic       halt,
  output logic [2:0] step
);

  // Encoding doubles as the externally visible step code.
  typedef enum logic [2:0] {
    ST_T0   = 3'd0,
    ST_T1   = 3'd1,
    ST_T2   = 3'd2,
    ST_T3   = 3'd3,
    ST_T4   = 3'd4,
    ST_IDLE = 3'd5,
    ST_HALT = 3'd6
  } state_t;

  localparam logic [3:0] OP_LDA = 4'h1;
  localparam logic [3:0] OP_ADD = 4'h2;
  localparam logic [3:0] OP_SUB = 4'h3;
  localparam logic [3:0] OP_STA = 4'h4;
  localparam logic [3:0] OP_LDI = 4'h5;
  localparam logic [3:0] OP_JMP = 4'h6;
`ifdef CTRL_COND_JMP_EN
  localparam logic [3:0] OP_JC  = 4'h7;
  localparam logic [3:0] OP_JZ  = 4'h8;
`endif
  localparam logic [3:0] OP_OUT = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;

  state_t state_q, state_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (en) begin
      case (state_q)
        ST_IDLE: state_d = ST_T0;
        ST_T0:   state_d = ST_T1;
        ST_T1:   state_d = ST_T2;
        ST_T2: begin
          case (ir_opcode)
            OP_HLT:                         state_d = ST_HALT;
            OP_LDA, OP_ADD, OP_SUB, OP_STA: state_d = ST_T3;
            default:                        state_d = ST_T0;
          endcase
        end
        ST_T3: begin
          case (ir_opcode)
            OP_ADD, OP_SUB: state_d = ST_T4;
            default:        state_d = ST_T0;
          endcase
        end
        ST_T4:   state_d = ST_T0;
        ST_HALT: state_d = ST_HALT;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Control decode; en low forces every enable off while the state holds.
  always_comb begin
    pc_out    = 1'b0;
    pc_inc    = 1'b0;
    pc_load   = 1'b0;
    mar_wen   = 1'b0;
    ram_oen   = 1'b0;
    ram_wen   = 1'b0;
    ir_wen    = 1'b0;
    ir_oen    = 1'b0;
    a_wen     = 1'b0;
    a_oen     = 1'b0;
    b_wen     = 1'b0;
    alu_oen   = 1'b0;
    alu_sub   = 1'b0;
    flags_wen = 1'b0;
    out_wen   = 1'b0;
    if (en) begin
      case (state_q)
        ST_T0: begin
          pc_out  = 1'b1;
          mar_wen = 1'b1;
        end
        ST_T1: begin
          ram_oen = 1'b1;
          ir_wen  = 1'b1;
          pc_inc  = 1'b1;
        end
        ST_T2: begin
          case (ir_opcode)
            OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
              ir_oen  = 1'b1;
              mar_wen = 1'b1;
            end
            OP_LDI: begin
              ir_oen = 1'b1;
              a_wen  = 1'b1;
            end
            OP_JMP: begin
              ir_oen  = 1'b1;
              pc_load = 1'b1;
            end
`ifdef CTRL_COND_JMP_EN
            OP_JC: begin
              ir_oen  = 1'b1;
              pc_load = carry_f;
            end
            OP_JZ: begin
              ir_oen  = 1'b1;
              pc_load = zero_f;
            end
`endif
            OP_OUT: begin
              a_oen   = 1'b1;
              out_wen = 1'b1;
            end
            default: ;
          endcase
        end
        ST_T3: begin
          case (ir_opcode)
            OP_LDA: begin
              ram_oen = 1'b1;
              a_wen   = 1'b1;
            end
            OP_ADD, OP_SUB: begin
              ram_oen = 1'b1;
              b_wen   = 1'b1;
            end
            OP_STA: begin
              a_oen   = 1'b1;
              ram_wen = 1'b1;
            end
            default: ;
          endcase
        end
        ST_T4: begin
          alu_oen   = 1'b1;
          a_wen     = 1'b1;
          flags_wen = 1'b1;
          alu_sub   = (ir_opcode == OP_SUB);
        end
        default: ;
      endcase
    end
  end

`ifndef CTRL_COND_JMP_EN
  logic unused_flags;
  assign unused_flags = carry_f | zero_f;
`endif

  assign halt = (state_q == ST_HALT);
  assign step = state_q;

endmodule

// File: tb/tb_cpu_ctrl_seq.sv
// Self-checking bench for cpu_ctrl_seq: directed steps plus randomized instruction stream.
module tb_cpu_ctrl_seq;
  logic       clk, rst, en;
  logic [3:0] ir_opcode;
  logic       carry_f, zero_f;
  logic pc_out, pc_inc, pc_load, mar_wen, ram_oen, ram_wen, ir_wen, ir_oen;
  logic a_wen, a_oen, b_wen, alu_oen, alu_sub, flags_wen, out_wen, halt;
  logic [2:0] step;
  logic [14:0] outs;

  int checks = 0;
  int errors = 0;

  localparam logic [14:0] PC_OUT = 15'h4000, PC_INC = 15'h2000, PC_LOAD = 15'h1000,
    MAR_WEN = 15'h0800, RAM_OEN = 15'h0400, RAM_WEN = 15'h0200, IR_WEN = 15'h0100,
    IR_OEN = 15'h0080, A_WEN = 15'h0040, A_OEN = 15'h0020, B_WEN = 15'h0010,
    ALU_OEN = 15'h0008, ALU_SUB = 15'h0004, FLAGS_WEN = 15'h0002, OUT_WEN = 15'h0001;

  cpu_ctrl_seq dut (
    .clk(clk), .rst(rst), .en(en), .ir_opcode(ir_opcode), .carry_f(carry_f), .zero_f(zero_f),
    .pc_out(pc_out), .pc_inc(pc_inc), .pc_load(pc_load), .mar_wen(mar_wen),
    .ram_oen(ram_oen), .ram_wen(ram_wen), .ir_wen(ir_wen), .ir_oen(ir_oen),
    .a_wen(a_wen), .a_oen(a_oen), .b_wen(b_wen), .alu_oen(alu_oen), .alu_sub(alu_sub),
    .flags_wen(flags_wen), .out_wen(out_wen), .halt(halt), .step(step)
  );

  assign outs = {pc_out, pc_inc, pc_load, mar_wen, ram_oen, ram_wen, ir_wen, ir_oen,
                 a_wen, a_oen, b_wen, alu_oen, alu_sub, flags_wen, out_wen};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Instruction length in clocks, counting the two fetch steps.
  function automatic int ilen(input logic [3:0] op);
    case (op)
      4'h1, 4'h4: return 4;
      4'h2, 4'h3: return 5;
      default:    return 3;
    endcase
  endfunction

  // Expected enable set for micro-step idx of instruction op.
  function automatic logic [14:0] uvec(input logic [3:0] op, input int idx,
                                       input logic c, input logic z);
    logic [14:0] addr, v;
    addr = IR_OEN | MAR_WEN;
    if (idx == 0) return PC_OUT | MAR_WEN;
    if (idx == 1) return RAM_OEN | IR_WEN | PC_INC;
    v = '0;
    case (op)
      4'h1: v = (idx == 2) ? addr : (RAM_OEN | A_WEN);
      4'h2, 4'h3: begin
        if (idx == 2)      v = addr;
        else if (idx == 3) v = RAM_OEN | B_WEN;
        else               v = ALU_OEN | A_WEN | FLAGS_WEN | ((op == 4'h3) ? ALU_SUB : 15'h0);
      end
      4'h4: v = (idx == 2) ? addr : (A_OEN | RAM_WEN);
      4'h5: v = IR_OEN | A_WEN;
      4'h6: v = IR_OEN | PC_LOAD;
`ifdef CTRL_COND_JMP_EN
      4'h7: v = IR_OEN | (c ? PC_LOAD : 15'h0);
      4'h8: v = IR_OEN | (z ? PC_LOAD : 15'h0);
`endif
      4'hE: v = A_OEN | OUT_WEN;
      default: v = '0;
    endcase
    return v;
  endfunction

  // Runs one instruction starting from T0; optionally freezes at step fz_idx for fz_len clocks.
  task automatic run_instr(input logic [3:0] op, input logic c, input logic z,
                           input int fz_idx, input int fz_len);
    ir_opcode = op;
    carry_f   = c;
    zero_f    = z;
    for (int i = 0; i < ilen(op); i++) begin
      if (i == fz_idx) begin
        en = 1'b0;
        for (int k = 0; k < fz_len; k++) begin
          #1;
          chk("frz_outs", 32'(outs), 32'h0);
          chk("frz_step", 32'(step), 32'(i));
          tick();
        end
        en = 1'b1;
      end
      #1;
      chk($sformatf("step_op%0h_%0d", op, i), 32'(step), 32'(i));
      chk($sformatf("outs_op%0h_%0d", op, i), 32'(outs), 32'(uvec(op, i, c, z)));
      chk("halt_low", 32'(halt), 32'h0);
      chk("bus_inv", 32'($countones({pc_out, ram_oen, ir_oen, a_oen, alu_oen}) <= 1), 32'h1);
      tick();
    end
  endtask

  initial begin
    logic [3:0] op;
    int fi;
    rst = 1'b1; en = 1'b1; ir_opcode = 4'h0; carry_f = 1'b0; zero_f = 1'b0;
    tick();
    tick();
    chk("rst_step", 32'(step), 32'h5);
    chk("rst_outs", 32'(outs), 32'h0);
    chk("rst_halt", 32'(halt), 32'h0);
    rst = 1'b0;
    #1;
    chk("idle_step", 32'(step), 32'h5);
    chk("idle_outs", 32'(outs), 32'h0);
    tick();

    run_instr(4'h5, 1'b0, 1'b0, -1, 0);   // LDI
    run_instr(4'h2, 1'b0, 1'b0, -1, 0);   // ADD
    run_instr(4'h3, 1'b0, 1'b0, -1, 0);   // SUB
    run_instr(4'h8, 1'b0, 1'b1, -1, 0);   // JZ taken
    run_instr(4'h8, 1'b1, 1'b0, -1, 0);   // JZ not taken
    run_instr(4'h7, 1'b1, 1'b0, -1, 0);   // JC taken
    run_instr(4'h1, 1'b0, 1'b0, 3, 4);    // LDA frozen in T3

    for (int n = 0; n < 60; n++) begin
      op = 4'($urandom_range(0, 14));
      fi = ($urandom_range(0, 3) == 0) ? $urandom_range(0, ilen(op) - 1) : -1;
      run_instr(op, 1'($urandom), 1'($urandom), fi, $urandom_range(1, 3));
    end

    run_instr(4'hF, 1'b0, 1'b0, -1, 0);   // HLT
    for (int k = 0; k < 10; k++) begin
      chk("hlt_step", 32'(step), 32'h6);
      chk("hlt_halt", 32'(halt), 32'h1);
      chk("hlt_outs", 32'(outs), 32'h0);
      tick();
    end
    #2 rst = 1'b1;
    #1;
    chk("arst_halt", 32'(halt), 32'h0);
    chk("arst_step", 32'(step), 32'h5);
    chk("arst_outs", 32'(outs), 32'h0);
    tick();
    rst = 1'b0;
    tick();
    chk("restart_step", 32'(step), 32'h0);
    chk("restart_outs", 32'(outs), 32'(PC_OUT | MAR_WEN));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/cpu_ctrl_seq.md
# cpu_ctrl_seq

Microcode sequencer for the 8-bit CPU: a Moore FSM that steps through fetch/decode/execute micro-steps and drives the write/read enables of the generic 8-bit registers, the RAM and the ALU. It sits directly upstream of every register instance. Its enable outputs connect to the registers' `wEN`/`rEN` ports, and it consumes the IR opcode nibble and the ALU flags. One instruction takes 3–5 clocks.

## Interface
- `clk`  in  1  system clock, rising edge
- `rst`  in  1  asynchronous, active-high reset
- `en`  in  1  run enable; 0 freezes the sequencer
- `ir_opcode`  in  4  IR[7:4]; valid from T2 onward
- `carry_f`, `zero_f`  in  1 each  registered ALU flags
- `pc_out`, `pc_inc`, `pc_load`  out  1 each  PC drive bus / increment / load from bus
- `mar_wen`  out  1  MAR write
- `ram_oen`, `ram_wen`  out  1 each  RAM drive bus / write
- `ir_wen`, `ir_oen`  out  1 each  IR write / drive operand IR[3:0] onto bus
- `a_wen`, `a_oen`, `b_wen`  out  1 each  A write / A drive / B write
- `alu_oen`, `alu_sub`, `flags_wen`  out  1 each  ALU drive / subtract / flag capture
- `out_wen`  out  1  output register write
- `halt`  out  1  CPU halted
- `step`  out  3  current micro-step: 0–4 = T0–T4, 5 = IDLE, 6 = HALT

## Operation
- States: IDLE, T0, T1, T2, T3, T4, HALT. All outputs decode combinationally from state and `ir_opcode`.
- Reset (async): state = IDLE. All control outputs = 0, `halt` = 0, `step` = 5.
- IDLE: no outputs asserted. Goes to T0 on the first clock with `en` = 1.
- T0: `pc_out`, `mar_wen`.
- T1: `ram_oen`, `ir_wen`, `pc_inc`.
- Execute steps by opcode. After the last listed step the FSM returns to T0.
  - 0 NOP: T2 with no signals.
  - 1 LDA: T2 `ir_oen`,`mar_wen`; T3 `ram_oen`,`a_wen`.
  - 2 ADD: T2 `ir_oen`,`mar_wen`; T3 `ram_oen`,`b_wen`; T4 `alu_oen`,`a_wen`,`flags_wen`.
  - 3 SUB: as ADD, with `alu_sub` = 1 in T4 only.
  - 4 STA: T2 `ir_oen`,`mar_wen`; T3 `a_oen`,`ram_wen`.
  - 5 LDI: T2 `ir_oen`,`a_wen`.
  - 6 JMP: T2 `ir_oen`,`pc_load`.
  - 7 JC / 8 JZ: T2 `ir_oen`. `pc_load` = `carry_f` for JC, `zero_f` for JZ, sampled in T2.
  - E OUT: T2 `a_oen`,`out_wen`.
  - F HLT: T2 with no signals, then HALT.
  - 9–D: treated as NOP.
- HALT: `halt` = 1 and all other outputs 0. Left only by `rst`.
- Bus invariant: at most one of `pc_out`, `ram_oen`, `ir_oen`, `a_oen`, `alu_oen` is high in any cycle.
- `en` = 0 in any state: state holds and all control outputs are forced to 0. `halt` and `step` still reflect the state. Execution resumes at the held step when `en` returns to 1.

## Timing
- Each state lasts one clock. The enables it asserts take effect at the rising edge that ends the state.
- Instruction lengths: NOP/LDI/JMP/JC/JZ/OUT = 3 clocks; LDA/STA = 4; ADD/SUB = 5.
- Fetch-to-fetch: T0 of the next instruction immediately follows the last execute step, with no bubble.
- `ir_opcode` is sampled only in T2–T4. It must stay stable from the T1 edge until the end of the instruction.
- Flags are sampled in T2 of JC/JZ. A flag written by the T4 of a preceding ADD/SUB is visible there.
- `rst` mid-instruction: outputs drop to 0 asynchronously and the FSM restarts from IDLE. The partial instruction is not completed.
- HLT: `halt` rises on the clock that ends its T2.

## Configuration
- `CTRL_COND_JMP_EN` defined: JC (7) and JZ (8) behave as above.
- `CTRL_COND_JMP_EN` undefined: opcodes 7 and 8 decode as NOP, `carry_f`/`zero_f` are unused, and `pc_load` is asserted only by JMP.

## Test plan
- Reset: assert `rst` for 2 clocks with `en` = 1, then release → `step` = 5 and all outputs 0. Next clock `step` = 0 with `pc_out` = `mar_wen` = 1.
- LDI: `ir_opcode` = 5 → T0/T1 fetch signals, then T2 `ir_oen` = `a_wen` = 1, then `step` returns to 0. Total 3 clocks.
- ADD vs SUB: opcode 2, then opcode 3 → 5 clocks each. `flags_wen` and `alu_oen` high only in T4. `alu_sub` = 1 only in T4 of SUB. Bus invariant holds every cycle.
- JZ, with the macro defined: `zero_f` = 1 → `pc_load` = 1 in T2. `zero_f` = 0 → `pc_load` = 0. With the macro undefined, `pc_load` = 0 in both cases.
- Freeze: drop `en` during T3 of LDA for 4 clocks → all outputs 0 and `step` = 3 held. After `en` returns, T3 `ram_oen`,`a_wen` is issued once, then T0.
- HLT and reset: opcode F → `halt` = 1 and `step` = 6, holding for 10 clocks. Then assert `rst` asynchronously mid-cycle → `halt` drops before the next clock edge and `step` = 5.
